// File: rtl/unidad_fetch_pkg.sv
// Shared types and constants for the fetch unit: FSM states, widths, reset PC.
package unidad_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/unidad_fetch_pc_reg.sv
// Fetch program counter: holds, loads a redirect target, or steps one word.
module pc_reg
  import unidad_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d, pc_q;

  // Load wins over increment; the add wraps modulo 2^32 for free.
  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_pc;
    else if (inc) pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/unidad_fetch.sv
// Single-slot instruction fetch: BOOT/FETCH/FAULT control, IR register with
// valid/ready handoff to decode, redirect handling and a handoff counter.
module unidad_fetch
  import unidad_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              ADDR_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [XLEN-1:0]    ir_pc,
  output logic [XLEN-1:0]    pc,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  fetch_state_e       state_d, state_q;
  logic [INSTR_W-1:0] ir_d, ir_q;
  logic [XLEN-1:0]    ir_pc_d, ir_pc_q;
  logic               ir_valid_d, ir_valid_q;
  logic               fault_d, fault_q;
  logic [15:0]        fetch_count_d, fetch_count_q;
  logic               pc_load, pc_inc;
  logic               handoff, slot_free;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  assign imem_addr = pc[ADDR_W+1:2];
  assign handoff   = ir_valid_q && ir_ready;
  assign slot_free = !ir_valid_q || ir_ready;

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    fault_d       = fault_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    // A handoff counts even when a redirect flushes the slot on the same edge.
    fetch_count_d = fetch_count_q + {15'd0, handoff};

    case (state_q)
      ST_BOOT, ST_FETCH: begin
        if (redirect_valid) begin
          ir_valid_d = 1'b0;
          if (is_word_aligned(redirect_pc)) begin
            pc_load = 1'b1;
            state_d = ST_FETCH;
          end else begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
        end else if (state_q == ST_BOOT) begin
          state_d = ST_FETCH;
        end else if (slot_free) begin
          ir_d       = imem_instr;
          ir_pc_d    = pc;
          ir_valid_d = 1'b1;
          pc_inc     = 1'b1;
        end
      end
      ST_FAULT: ;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/unidad_fetch.md
UNIDAD_FETCH -- requirements
Module: unidad_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded at reset.
REQ-002 Parameter ADDR_W, default 4, SHALL set the instruction-memory word-address width (16 words).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port imem_addr  output  ADDR_W  SHALL carry the word address, equal to pc[ADDR_W+1:2], driven combinationally.
REQ-006 Port imem_instr  input  32  SHALL carry the instruction returned combinationally by the instruction memory for imem_addr.
REQ-007 Port redirect_valid  input  1  SHALL request a PC change (branch/jump) this cycle.
REQ-008 Port redirect_pc  input  32  SHALL carry the redirect target byte address.
REQ-009 Port ir_valid  output  1  SHALL indicate ir/ir_pc hold a valid fetched instruction.
REQ-010 Port ir_ready  input  1  SHALL indicate the decode stage accepts ir this cycle.
REQ-011 Port ir  output  32  SHALL carry the registered instruction.
REQ-012 Port ir_pc  output  32  SHALL carry the byte address ir was fetched from.
REQ-013 Port pc  output  32  SHALL carry the current fetch PC.
REQ-014 Port fault  output  1  SHALL flag a misaligned redirect; sticky.
REQ-015 Port fetch_count  output  16  SHALL count instructions handed to decode (ir_valid && ir_ready).

Function
REQ-016 FSM states SHALL be BOOT, FETCH, FAULT.
REQ-017 BOOT SHALL last exactly one cycle after reset deassertion, performing no capture; then -> FETCH.
REQ-018 In FETCH, the output slot SHALL be free when !ir_valid || ir_ready.
REQ-019 In FETCH with slot free and no redirect: ir<=imem_instr, ir_pc<=pc, ir_valid<=1, pc<=pc+4 (one-cycle fetch latency).
REQ-020 In FETCH with ir_valid && !ir_ready and no redirect: pc, ir, ir_pc, ir_valid SHALL hold unchanged (stall).
REQ-021 redirect_valid with redirect_pc[1:0]==0 SHALL take priority: pc<=redirect_pc, ir_valid<=0 (flush), no capture that cycle, regardless of ir_ready.
REQ-022 A handoff (ir_valid && ir_ready) coinciding with a redirect SHALL still increment fetch_count.
REQ-023 redirect_valid with redirect_pc[1:0]!=0 SHALL transition to FAULT: fault<=1, ir_valid<=0, pc unchanged.
REQ-024 FAULT SHALL be terminal until reset; no captures, redirects ignored, pc frozen.
REQ-025 redirect_valid in BOOT SHALL be honoured as in FETCH (pc load or FAULT); BOOT still exits after one cycle.
REQ-026 pc+4 SHALL wrap modulo 2^32; imem_addr SHALL alias every 2^(ADDR_W+2) bytes (64 B default) with no error.
REQ-027 fetch_count SHALL wrap from 16'hFFFF to 0.
REQ-028 ir and ir_pc SHALL change only on a capture.

Reset
REQ-029 On reset: state=BOOT, pc=RESET_PC, ir=32'h0, ir_pc=32'h0, ir_valid=0, fault=0, fetch_count=0.
REQ-030 Reset asserted mid-stall or in FAULT SHALL discard all state in the same edge with no handoff counted.

Structure
REQ-031 Package unidad_fetch_pkg SHALL hold the FSM state enum, default RESET_PC, and the instruction/PC width constants (32).
REQ-032 The PC register with increment/redirect mux SHALL be a sub-module named pc_reg; the FSM and IR register stay in unidad_fetch.

Verification
REQ-033 Reset, ROM words 0..3 = 11111111,22222222,33333333,44444444, ir_ready=1 -> after BOOT, ir sequence 11111111,22222222,... with ir_pc 0,4,8,C on consecutive cycles.
REQ-034 ir_ready=0 for 3 cycles with ir_valid=1, ir_pc=8 -> ir, ir_pc, pc (=C) stable; ready high -> next ir_pc=C; fetch_count +1 per handoff only.
REQ-035 redirect_valid with redirect_pc=32'h20 while ir_valid=1, ir_ready=0 -> next cycle ir_valid=0, pc=20; following cycle ir_pc=20, ir=ROM[8].
REQ-036 redirect_pc=32'h22 -> fault=1 next cycle, ir_valid=0 thereafter; later valid redirects ignored; reset clears fault and pc=RESET_PC.
REQ-037 RESET_PC=32'h3C, ir_ready=1 -> ir_pc sequence 3C,40,44 with imem_addr F,0,1 (aliasing).
REQ-038 Preload fetch_count path with 65536 handoffs -> fetch_count wraps to 0.
